// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: frame geometry and FSM state type shared by the ADC SPI responder.
package adc_spi_pkg;
    localparam int FRAME_BITS      = 16;
    localparam int DATA_W          = 12;
    localparam int ADDR_W          = 3;
    localparam int ADDR_FIRST_EDGE = 3;
    localparam int LEAD_ZEROS      = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL} resp_state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchronizer for one SPI pin with rise/fall pulses.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    // Top bit is the extra delayed copy used only for edge detection.
    logic [SYNC_STAGES:0] sr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= {sr_q[SYNC_STAGES-1:0], pin_i};
    end

    assign level_o = sr_q[SYNC_STAGES-1];
    assign rise_o  = sr_q[SYNC_STAGES-1] & ~sr_q[SYNC_STAGES];
    assign fall_o  = ~sr_q[SYNC_STAGES-1] & sr_q[SYNC_STAGES];
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI slave emulating an 8-channel 12-bit serial ADC.
// Each frame returns the channel addressed by the previous completed frame.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_sclk,
    input  logic                   spi_csn,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic                   spi_miso_oe,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    output logic                   addr_valid,
    output logic [ADDR_W-1:0]      addr,
    output logic                   frame_done,
    output logic                   frame_aborted,
    output logic [15:0]            frame_cnt,
    output logic                   busy
);
    localparam logic [4:0] A_FIRST = 5'(ADDR_FIRST_EDGE);
    localparam logic [4:0] A_LAST  = 5'(ADDR_FIRST_EDGE + ADDR_W - 1);
    localparam logic [4:0] F_LAST  = 5'(FRAME_BITS);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic csn_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .pin_i(spi_sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
        .clk(clk), .rst_n(rst_n), .pin_i(spi_csn),
        .level_o(csn_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .pin_i(spi_mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_lvl, csn_lvl, mosi_rise, mosi_fall};

    // Channels beyond N_CH read as zero.
    logic [DATA_W-1:0] ch_arr [2**ADDR_W];
    for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_ch
        if (k < N_CH) begin : g_on
            assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
        end else begin : g_off
            assign ch_arr[k] = '0;
        end
    end

    resp_state_t           state_q;
    logic [4:0]            bit_cnt_q;
    logic [FRAME_BITS-1:0] word_q;
    logic [ADDR_W-2:0]     addr_sh_q;
    logic [ADDR_W-1:0]     cur_ch_q;
    logic [FRAME_BITS-1:0] load_d;
    logic [4:0]            cnt_d;

    assign load_d = {{LEAD_ZEROS{1'b0}}, ch_arr[cur_ch_q]};
    assign cnt_d  = bit_cnt_q + 5'd1;
    assign busy   = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            word_q        <= '0;
            addr_sh_q     <= '0;
            cur_ch_q      <= '0;
            spi_miso      <= 1'b0;
            spi_miso_oe   <= 1'b0;
            addr_valid    <= 1'b0;
            addr          <= '0;
            frame_done    <= 1'b0;
            frame_aborted <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            addr_valid    <= 1'b0;
            frame_done    <= 1'b0;
            frame_aborted <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        word_q      <= load_d;
                        bit_cnt_q   <= '0;
                        spi_miso    <= load_d[FRAME_BITS-1];
                        spi_miso_oe <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        frame_aborted <= 1'b1;
                        spi_miso      <= 1'b0;
                        spi_miso_oe   <= 1'b0;
                        state_q       <= IDLE;
                    end else if (sclk_rise) begin
                        bit_cnt_q <= cnt_d;
                        if (cnt_d >= A_FIRST && cnt_d < A_LAST) addr_sh_q <= {addr_sh_q[0], mosi_lvl};
                        if (cnt_d == A_LAST) begin
                            addr       <= {addr_sh_q, mosi_lvl};
                            addr_valid <= 1'b1;
                        end
                        if (cnt_d == F_LAST) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            cur_ch_q   <= addr;
                            state_q    <= TAIL;
                        end
                    // The falling edge preceding rising edge 1 leaves bit 15 on the line.
                    end else if (sclk_fall && bit_cnt_q != 5'd0) begin
                        word_q   <= {word_q[FRAME_BITS-2:0], 1'b0};
                        spi_miso <= word_q[FRAME_BITS-2];
                    end
                end
                TAIL: begin
                    if (cs_rise) begin
                        spi_miso    <= 1'b0;
                        spi_miso_oe <= 1'b0;
                        state_q     <= IDLE;
                    end else if (sclk_fall) begin
                        word_q    <= load_d;
                        bit_cnt_q <= '0;
                        spi_miso  <= load_d[FRAME_BITS-1];
                        state_q   <= SHIFT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed SPI master driving the ADC responder with hand-computed words.
module tb_adc_spi_responder;
    localparam int NCH  = 6;
    localparam int HALF = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b1;
    logic csn = 1'b1;
    logic mosi = 1'b0;
    logic [NCH*12-1:0] ch_data = '0;
    logic spi_miso, spi_miso_oe, addr_valid, frame_done, frame_aborted, busy;
    logic [2:0] addr;
    logic [15:0] frame_cnt;

    int n_pass = 0, n_chk = 0;
    int n_av = 0, n_fd = 0, n_fa = 0;

    adc_spi_responder #(.N_CH(NCH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(sclk), .spi_csn(csn), .spi_mosi(mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .ch_data(ch_data),
        .addr_valid(addr_valid), .addr(addr),
        .frame_done(frame_done), .frame_aborted(frame_aborted),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (addr_valid)    n_av++;
        if (frame_done)    n_fd++;
        if (frame_aborted) n_fa++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        ch_data[k*12 +: 12] = v;
    endtask

    task automatic cs_low;
        csn = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_high;
        csn = 1'b1;
        wait_clks(2*HALF);
    endtask

    task automatic xfer(input logic [2:0] a, input int from, input int to, inout logic [15:0] w);
        for (int b = from; b <= to; b++) begin
            sclk = 1'b0;
            if (b >= 2 && b <= 4) mosi = a[4-b];
            wait_clks(HALF);
            w[15-b] = spi_miso;
            sclk = 1'b1;
            wait_clks(HALF);
        end
    endtask

    task automatic frame(input logic [2:0] a, output logic [15:0] w);
        w = '0;
        cs_low();
        xfer(a, 0, 15, w);
        cs_high();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(2);
        n_chk++;
        if ({spi_miso, spi_miso_oe, addr_valid, addr, frame_done, frame_aborted, busy} !== 9'd0)
            $display("FAIL reset_flags: got %b expected 0", {spi_miso, spi_miso_oe, addr_valid, addr, frame_done, frame_aborted, busy});
        else n_pass++;
        n_chk++;
        if (frame_cnt !== 16'd0) $display("FAIL reset_cnt: got %h expected 0000", frame_cnt);
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [15:0] w;
        int av0, fd0;
        set_ch(0, 12'hABC);
        set_ch(5, 12'h7E7);
        av0 = n_av;
        fd0 = n_fd;
        frame(3'd5, w);
        n_chk++;
        if (w !== 16'h0ABC) $display("FAIL basic_word: got %h expected 0abc", w); else n_pass++;
        n_chk++;
        if (n_av - av0 !== 1) $display("FAIL basic_av: got %0d pulses expected 1", n_av - av0); else n_pass++;
        n_chk++;
        if (addr !== 3'd5) $display("FAIL basic_addr: got %0d expected 5", addr); else n_pass++;
        n_chk++;
        if (n_fd - fd0 !== 1) $display("FAIL basic_done: got %0d pulses expected 1", n_fd - fd0); else n_pass++;
        n_chk++;
        if (frame_cnt !== 16'd1) $display("FAIL basic_cnt: got %0d expected 1", frame_cnt); else n_pass++;
    endtask

    task automatic test_second;
        logic [15:0] w;
        set_ch(5, 12'h123);
        frame(3'd2, w);
        n_chk++;
        if (w !== 16'h0123) $display("FAIL second_word: got %h expected 0123", w); else n_pass++;
        n_chk++;
        if (addr !== 3'd2) $display("FAIL second_addr: got %0d expected 2", addr); else n_pass++;
        n_chk++;
        if (frame_cnt !== 16'd2) $display("FAIL second_cnt: got %0d expected 2", frame_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] w1, w2;
        int fd0;
        set_ch(2, 12'h111);
        set_ch(1, 12'h222);
        fd0 = n_fd;
        w1 = '0;
        w2 = '0;
        cs_low();
        xfer(3'd1, 0, 15, w1);
        xfer(3'd3, 0, 15, w2);
        cs_high();
        n_chk++;
        if (w1 !== 16'h0111) $display("FAIL b2b_word1: got %h expected 0111", w1); else n_pass++;
        n_chk++;
        if (w2 !== 16'h0222) $display("FAIL b2b_word2: got %h expected 0222", w2); else n_pass++;
        n_chk++;
        if (n_fd - fd0 !== 2) $display("FAIL b2b_done: got %0d pulses expected 2", n_fd - fd0); else n_pass++;
        n_chk++;
        if (frame_cnt !== 16'd4) $display("FAIL b2b_cnt: got %0d expected 4", frame_cnt); else n_pass++;
    endtask

    task automatic test_abort;
        logic [15:0] w;
        int fd0, fa0;
        set_ch(3, 12'h333);
        fd0 = n_fd;
        fa0 = n_fa;
        w = '0;
        cs_low();
        xfer(3'd6, 0, 7, w);
        n_chk++;
        if (busy !== 1'b1) $display("FAIL abort_busy: got %b expected 1", busy); else n_pass++;
        n_chk++;
        if (w[15:8] !== 8'h03) $display("FAIL abort_partial: got %h expected 03", w[15:8]); else n_pass++;
        n_chk++;
        if (addr !== 3'd6) $display("FAIL abort_addr: got %0d expected 6", addr); else n_pass++;
        csn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (spi_miso_oe !== 1'b1) $display("FAIL abort_oe_early: got %b expected 1", spi_miso_oe); else n_pass++;
        @(posedge clk);
        #1;
        n_chk++;
        if (spi_miso_oe !== 1'b0) $display("FAIL abort_oe_drop: got %b expected 0", spi_miso_oe); else n_pass++;
        wait_clks(2*HALF);
        n_chk++;
        if (n_fa - fa0 !== 1) $display("FAIL abort_pulse: got %0d pulses expected 1", n_fa - fa0); else n_pass++;
        n_chk++;
        if (n_fd !== fd0) $display("FAIL abort_nodone: got %0d pulses expected 0", n_fd - fd0); else n_pass++;
        n_chk++;
        if (frame_cnt !== 16'd4) $display("FAIL abort_cnt: got %0d expected 4", frame_cnt); else n_pass++;
        frame(3'd4, w);
        n_chk++;
        if (w !== 16'h0333) $display("FAIL abort_next_word: got %h expected 0333", w); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        logic [15:0] w;
        int fd0, fa0;
        set_ch(4, 12'h444);
        set_ch(0, 12'h5A5);
        fd0 = n_fd;
        fa0 = n_fa;
        w = '0;
        cs_low();
        xfer(3'd7, 0, 7, w);
        rst_n = 1'b0;
        wait_clks(1);
        rst_n = 1'b1;
        n_chk++;
        if ({spi_miso, spi_miso_oe, addr_valid, addr, frame_done, frame_aborted, busy} !== 9'd0)
            $display("FAIL midrst_flags: got %b expected 0", {spi_miso, spi_miso_oe, addr_valid, addr, frame_done, frame_aborted, busy});
        else n_pass++;
        n_chk++;
        if (frame_cnt !== 16'd0) $display("FAIL midrst_cnt: got %0d expected 0", frame_cnt); else n_pass++;
        xfer(3'd7, 8, 15, w);
        cs_high();
        n_chk++;
        if (n_fd !== fd0 || n_fa !== fa0)
            $display("FAIL midrst_pulses: got done %0d abort %0d expected 0 0", n_fd - fd0, n_fa - fa0);
        else n_pass++;
        frame(3'd7, w);
        n_chk++;
        if (w !== 16'h05A5) $display("FAIL midrst_word: got %h expected 05a5", w); else n_pass++;
        n_chk++;
        if (frame_cnt !== 16'd1) $display("FAIL midrst_next_cnt: got %0d expected 1", frame_cnt); else n_pass++;
    endtask

    task automatic test_out_of_range;
        logic [15:0] w;
        frame(3'd1, w);
        n_chk++;
        if (w !== 16'h0000) $display("FAIL oor_word: got %h expected 0000", w); else n_pass++;
        n_chk++;
        if (frame_cnt !== 16'd2) $display("FAIL oor_cnt: got %0d expected 2", frame_cnt); else n_pass++;
    endtask

    task automatic test_data_hold;
        logic [15:0] w;
        set_ch(1, 12'hFFF);
        w = '0;
        cs_low();
        xfer(3'd0, 0, 7, w);
        set_ch(1, 12'h000);
        xfer(3'd0, 8, 15, w);
        cs_high();
        n_chk++;
        if (w !== 16'h0FFF) $display("FAIL hold_word: got %h expected 0fff", w); else n_pass++;
        n_chk++;
        if (frame_cnt !== 16'd3) $display("FAIL hold_cnt: got %0d expected 3", frame_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
        test_out_of_range();
        test_data_hold();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
